// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the Fetch1 PC sequencer
package fetch_ctrl_pkg;

  // Sequencer states; the encoding is fixed so state can be decoded in debug dumps.
  typedef enum logic [1:0] {
    BOOT0 = 2'd0,
    BOOT1 = 2'd1,
    RUN   = 2'd2,
    PEND  = 2'd3
  } fetch_state_e;

  // Redirect source ranking; a larger value wins arbitration.
  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_BR   = 2'd1,
    PRIO_ERTN = 2'd2,
    PRIO_EXC  = 2'd3
  } redirect_prio_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1C00_0000;

endpackage

// File: rtl/redirect_arb.sv
// rtl/redirect_arb.sv - fixed-priority select among exception, ertn and branch redirects
module redirect_arb
  import fetch_ctrl_pkg::*;
(
  input  logic           exc_valid,
  input  logic [31:0]    exc_target,
  input  logic           ertn_valid,
  input  logic [31:0]    ertn_target,
  input  logic           br_valid,
  input  logic [31:0]    br_target,
  output logic           sel_valid,
  output logic [31:0]    sel_target,
  output redirect_prio_e sel_prio
);

  // Exception beats ertn beats branch; targets are passed through untouched.
  always_comb begin
    sel_valid  = 1'b0;
    sel_target = 32'h0;
    sel_prio   = PRIO_NONE;
    if (exc_valid) begin
      sel_valid  = 1'b1;
      sel_target = exc_target;
      sel_prio   = PRIO_EXC;
    end else if (ertn_valid) begin
      sel_valid  = 1'b1;
      sel_target = ertn_target;
      sel_prio   = PRIO_ERTN;
    end else if (br_valid) begin
      sel_valid  = 1'b1;
      sel_target = br_target;
      sel_prio   = PRIO_BR;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - Fetch1 PC sequencer: boot, redirects, miss hold and pending redirect
module fetch_pc_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ic_busy,
  input  logic        f2_stall,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        ertn_valid,
  input  logic [31:0] ertn_target,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic [31:0] next_pc,
  output logic        stall_RegInput,
  output logic        clear_RegInput,
  output logic        kill_f2
);

  fetch_state_e   state;
  fetch_state_e   state_next;
  logic [31:0]    pend_target;
  redirect_prio_e pend_prio;
  logic           pend_load;
  logic           pend_clear;
  logic           sel_valid;
  logic [31:0]    sel_target;
  redirect_prio_e sel_prio;
  logic           live_wins;

  redirect_arb u_arb (
    .exc_valid   (exc_valid),
    .exc_target  (exc_target),
    .ertn_valid  (ertn_valid),
    .ertn_target (ertn_target),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .sel_valid   (sel_valid),
    .sel_target  (sel_target),
    .sel_prio    (sel_prio)
  );

  // A live redirect displaces the buffered one unless it ranks strictly lower.
  assign live_wins = sel_valid && (sel_prio >= pend_prio);

  // State register; reset drops straight to BOOT0 so outputs go to reset values at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT0;
    end else begin
      state <= state_next;
    end
  end

  // Pending redirect buffer, loaded during a miss and emptied when the miss completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_target <= 32'h0;
      pend_prio   <= PRIO_NONE;
    end else if (pend_load) begin
      pend_target <= sel_target;
      pend_prio   <= sel_prio;
    end else if (pend_clear) begin
      pend_target <= 32'h0;
      pend_prio   <= PRIO_NONE;
    end
  end

  // Next-state and Fetch1 control; default is hold-free reload of the current pc.
  always_comb begin
    state_next     = state;
    next_pc        = pc;
    stall_RegInput = 1'b0;
    clear_RegInput = 1'b0;
    kill_f2        = 1'b0;
    pend_load      = 1'b0;
    pend_clear     = 1'b0;
    case (state)
      BOOT0: begin
        clear_RegInput = 1'b1;
        kill_f2        = 1'b1;
        next_pc        = RESET_PC;
        state_next     = BOOT1;
      end
      BOOT1: begin
        kill_f2    = 1'b1;
        next_pc    = RESET_PC;
        state_next = RUN;
      end
      RUN: begin
        if (ic_busy) begin
          stall_RegInput = 1'b1;
          if (sel_valid) begin
            pend_load  = 1'b1;
            state_next = PEND;
          end
        end else if (sel_valid) begin
          next_pc = sel_target;
          kill_f2 = 1'b1;
        end else if (f2_stall) begin
          stall_RegInput = 1'b1;
        end else begin
          next_pc = pc + 32'd4;
        end
      end
      PEND: begin
        if (ic_busy) begin
          stall_RegInput = 1'b1;
          pend_load      = live_wins;
        end else begin
          next_pc    = live_wins ? sel_target : pend_target;
          kill_f2    = 1'b1;
          pend_clear = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed and randomized self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RPC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        ic_busy = 1'b0;
  logic        f2_stall = 1'b0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_target = 32'h0;
  logic        ertn_valid = 1'b0;
  logic [31:0] ertn_target = 32'h0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] next_pc;
  logic        stall_RegInput;
  logic        clear_RegInput;
  logic        kill_f2;

  int checks = 0;
  int failures = 0;

  // Reference model: cycles since reset release, plus an optional buffered redirect.
  int          m_boot = 0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pt = 32'h0;
  int          m_pr = 0;
  int          n_boot;
  bit          n_pend;
  logic [31:0] n_pt;
  int          n_pr;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .ic_busy        (ic_busy),
    .f2_stall       (f2_stall),
    .exc_valid      (exc_valid),
    .exc_target     (exc_target),
    .ertn_valid     (ertn_valid),
    .ertn_target    (ertn_target),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .next_pc        (next_pc),
    .stall_RegInput (stall_RegInput),
    .clear_RegInput (clear_RegInput),
    .kill_f2        (kill_f2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] p, input logic ib, input logic fs,
                        input logic ev, input logic [31:0] et,
                        input logic rv, input logic [31:0] rt,
                        input logic bv, input logic [31:0] bt);
    pc = p; ic_busy = ib; f2_stall = fs;
    exc_valid = ev; exc_target = et;
    ertn_valid = rv; ertn_target = rt;
    br_valid = bv; br_target = bt;
  endtask

  // Sample at the falling edge, compare against the model, and stage model next state.
  task automatic eval(input string tag);
    int          rank;
    logic [31:0] live_t;
    logic [31:0] e_npc;
    logic        e_stall, e_clear, e_kill;
    bit          take;
    @(negedge clk);
    rank = 0; live_t = 32'h0;
    if (exc_valid) begin rank = 3; live_t = exc_target; end
    else if (ertn_valid) begin rank = 2; live_t = ertn_target; end
    else if (br_valid) begin rank = 1; live_t = br_target; end
    n_boot = m_boot; n_pend = m_pend; n_pt = m_pt; n_pr = m_pr;
    e_npc = pc; e_stall = 1'b0; e_clear = 1'b0; e_kill = 1'b0;
    if (rst) begin
      e_clear = 1'b1; e_kill = 1'b1; e_npc = RPC;
      n_boot = 0; n_pend = 1'b0; n_pr = 0;
    end else if (m_boot == 0) begin
      e_clear = 1'b1; e_kill = 1'b1; e_npc = RPC; n_boot = 1;
    end else if (m_boot == 1) begin
      e_kill = 1'b1; e_npc = RPC; n_boot = 2;
    end else if (m_pend) begin
      take = (rank > 0) && (rank >= m_pr);
      if (ic_busy) begin
        e_stall = 1'b1;
        if (take) begin n_pt = live_t; n_pr = rank; end
      end else begin
        e_npc = take ? live_t : m_pt;
        e_kill = 1'b1; n_pend = 1'b0; n_pr = 0;
      end
    end else if (ic_busy) begin
      e_stall = 1'b1;
      if (rank > 0) begin n_pend = 1'b1; n_pt = live_t; n_pr = rank; end
    end else if (rank > 0) begin
      e_npc = live_t; e_kill = 1'b1;
    end else if (f2_stall) begin
      e_stall = 1'b1;
    end else begin
      e_npc = pc + 32'd4;
    end
    check({tag, ".next_pc"}, next_pc, e_npc);
    check({tag, ".stall"}, {31'b0, stall_RegInput}, {31'b0, e_stall});
    check({tag, ".clear"}, {31'b0, clear_RegInput}, {31'b0, e_clear});
    check({tag, ".kill"}, {31'b0, kill_f2}, {31'b0, e_kill});
  endtask

  task automatic adv();
    @(posedge clk);
    m_boot = n_boot; m_pend = n_pend; m_pt = n_pt; m_pr = n_pr;
    #1;
  endtask

  initial begin
    // Reset sequence: three cycles in reset, then BOOT0, BOOT1, first sequential fetch.
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin eval("rst"); adv(); end
    rst = 1'b0;
    eval("boot0"); check("boot0_clear_const", {31'b0, clear_RegInput}, 32'd1); adv();
    eval("boot1"); check("boot1_npc_const", next_pc, 32'h1C00_0000); adv();
    set_in(32'h1C00_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    eval("run0"); check("run0_npc_const", next_pc, 32'h1C00_0004); adv();

    // Downstream stall, release, and 32-bit wrap.
    set_in(32'h1C00_0010, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    eval("f2s1"); adv();
    eval("f2s2"); check("f2s_npc_const", next_pc, 32'h1C00_0010); adv();
    f2_stall = 1'b0;
    eval("f2rel"); check("f2rel_npc_const", next_pc, 32'h1C00_0014); adv();
    pc = 32'hFFFF_FFFC;
    eval("wrap"); check("wrap_npc_const", next_pc, 32'h0); adv();

    // Simultaneous exc and br with f2_stall: exc wins, stall overridden.
    set_in(32'h1C00_0020, 1'b0, 1'b1, 1'b1, 32'h1C00_8000, 1'b0, 32'h0, 1'b1, 32'h1C00_0400);
    eval("multi"); check("multi_npc_const", next_pc, 32'h1C00_8000); adv();

    // Branch during miss, later overridden by ertn before the miss completes.
    set_in(32'h1C00_0030, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0400);
    eval("pend_br"); adv();
    set_in(32'h1C00_0030, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    eval("pend_hold"); adv();
    set_in(32'h1C00_0030, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C00_2000, 1'b0, 32'h0);
    eval("pend_ertn"); adv();
    set_in(32'h1C00_0030, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    eval("pend_done"); check("ovr_npc_const", next_pc, 32'h1C00_2000); adv();
    eval("pend_after"); adv();

    // Buffered exc survives a later, lower-ranked branch.
    set_in(32'h1C00_0040, 1'b1, 1'b0, 1'b1, 32'h1C00_8000, 1'b0, 32'h0, 1'b0, 32'h0);
    eval("exc_miss"); adv();
    set_in(32'h1C00_0040, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0400);
    eval("br_drop"); adv();
    ic_busy = 1'b0;
    eval("exc_done"); check("drop_npc_const", next_pc, 32'h1C00_8000); adv();

    // Reset while a redirect is pending: immediate reset outputs, no stale target later.
    set_in(32'h1C00_0050, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0400);
    eval("pend_rst"); adv();
    set_in(32'h1C00_0050, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("async_clear", {31'b0, clear_RegInput}, 32'd1);
    check("async_npc", next_pc, RPC);
    check("async_stall", {31'b0, stall_RegInput}, 32'd0);
    eval("mid_rst"); adv();
    rst = 1'b0; ic_busy = 1'b0;
    eval("reboot0"); adv();
    eval("reboot1"); check("reboot1_npc_const", next_pc, RPC); adv();
    eval("rerun"); check("rerun_npc_const", next_pc, 32'h1C00_0054); adv();

    // Randomized traffic, including unaligned targets and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(15) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} & 32'hFFFF_FFFC,
             $urandom_range(9) < 4, $urandom_range(3) == 0,
             $urandom_range(9) == 0, $urandom(),
             $urandom_range(9) == 0, $urandom(),
             $urandom_range(4) == 0, $urandom());
      rst = ($urandom_range(99) == 0);
      eval("rand");
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
